// File: rtl/chroma_cline_req_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chroma_cline_req_sequencer: expands one chroma block request into a        |
// | raster-ordered stream of cache-line coordinates.     Rev 1.0               |
// +----------------------------------------------------------------------------+
module chroma_cline_req_sequencer #(
  parameter int C_L_H_SIZE_C = 3,
  parameter int C_L_V_SIZE_C = 2,
  parameter int X_WDTH       = 11,
  parameter int Y_WDTH       = 11
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid_in,
  output logic                             req_ready_out,
  input  logic [X_WDTH-1:0]                start_x_in,
  input  logic [Y_WDTH-1:0]                start_y_in,
  input  logic [1:0]                       delta_x_in,
  input  logic [1:0]                       delta_y_in,
  output logic                             line_valid_out,
  input  logic                             line_ready_in,
  output logic [X_WDTH-C_L_H_SIZE_C-1:0]   line_x_out,
  output logic [Y_WDTH-C_L_V_SIZE_C-1:0]   line_y_out,
  output logic                             line_last_out,
  output logic                             busy_out
);

  localparam int LX_W = X_WDTH - C_L_H_SIZE_C;
  localparam int LY_W = Y_WDTH - C_L_V_SIZE_C;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t            state_q,  state_d;
  logic [LX_W-1:0]   base_x_q, base_x_d;
  logic [LY_W-1:0]   base_y_q, base_y_d;
  logic [1:0]        dx_q,     dx_d;
  logic [1:0]        dy_q,     dy_d;
  logic [1:0]        ox_q,     ox_d;
  logic [1:0]        oy_q,     oy_d;

  logic              at_last;
  logic              issuing;
  logic              unused_bits;

  // Sub-line pixel offsets never affect which cache line is addressed.
  assign unused_bits = ^{start_x_in[C_L_H_SIZE_C-1:0], start_y_in[C_L_V_SIZE_C-1:0]};

  assign issuing = (state_q == ISSUE);
  assign at_last = (ox_q == dx_q) && (oy_q == dy_q);

  always_comb begin
    state_d  = state_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    case (state_q)
      IDLE: begin
        if (req_valid_in) begin
          state_d  = ISSUE;
          base_x_d = start_x_in[X_WDTH-1:C_L_H_SIZE_C];
          base_y_d = start_y_in[Y_WDTH-1:C_L_V_SIZE_C];
          dx_d     = delta_x_in;
          dy_d     = delta_y_in;
          ox_d     = 2'd0;
          oy_d     = 2'd0;
        end
      end
      ISSUE: begin
        if (line_ready_in) begin
          if (at_last) begin
            state_d = IDLE;
          end else if (ox_q < dx_q) begin
            ox_d = ox_q + 2'd1;
          end else begin
            ox_d = 2'd0;
            oy_d = oy_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      base_x_q <= '0;
      base_y_q <= '0;
      dx_q     <= 2'd0;
      dy_q     <= 2'd0;
      ox_q     <= 2'd0;
      oy_q     <= 2'd0;
    end else begin
      state_q  <= state_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
    end
  end

  // Coordinates wrap modulo the line-grid size; outputs are zero while idle.
  assign req_ready_out  = !issuing;
  assign line_valid_out = issuing;
  assign busy_out       = issuing;
  assign line_last_out  = issuing && at_last;
  assign line_x_out     = issuing ? (base_x_q + {{(LX_W-2){1'b0}}, ox_q}) : '0;
  assign line_y_out     = issuing ? (base_y_q + {{(LY_W-2){1'b0}}, oy_q}) : '0;

endmodule
`default_nettype wire

// File: doc/chroma_cline_req_sequencer.md
Name: chroma_cline_req_sequencer

Overview:
- Sits directly downstream of the chroma cache-line-count stage in the reference-cache front end.
- Consumes one chroma reference block request: start coordinates plus the horizontal/vertical cache-line crossing counts (delta_x, delta_y).
- Expands each request into a raster-ordered stream of cache-line block coordinates for the chroma tag-lookup stage.
- Uses valid/ready handshakes on both sides.

Parameters:
- C_L_H_SIZE_C, 3, log2 of cache-line width in chroma pixels.
- C_L_V_SIZE_C, 2, log2 of cache-line height in chroma rows.
- X_WDTH, 11, width of chroma picture x coordinate.
- Y_WDTH, 11, width of chroma picture y coordinate.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- req_valid_in  in  1  request present.
- req_ready_out  out  1  sequencer can accept a request.
- start_x_in  in  X_WDTH  chroma x of the block's top-left pixel.
- start_y_in  in  Y_WDTH  chroma y of the block's top-left pixel.
- delta_x_in  in  2  extra cache-line columns crossed (0..3).
- delta_y_in  in  2  extra cache-line rows crossed (0..3).
- line_valid_out  out  1  line coordinate valid.
- line_ready_in  in  1  downstream accepts the line.
- line_x_out  out  X_WDTH-C_L_H_SIZE_C  cache-line column.
- line_y_out  out  Y_WDTH-C_L_V_SIZE_C  cache-line row.
- line_last_out  out  1  final line of the current request.
- busy_out  out  1  request in progress.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - line_valid_out=0, line_last_out=0, busy_out=0.
  - line_x_out=0, line_y_out=0.
  - req_ready_out=1 in the first cycle after reset is released.
- FSM states:
  - IDLE: req_ready_out=1, line_valid_out=0.
  - ISSUE: req_ready_out=0, line_valid_out=1, busy_out=1.
- IDLE->ISSUE on req_valid_in & req_ready_out. At that edge the block registers:
  - base_x = start_x_in >> C_L_H_SIZE_C
  - base_y = start_y_in >> C_L_V_SIZE_C
  - dx = delta_x_in, dy = delta_y_in
  - offsets ox=0, oy=0
- First line: presented on the cycle after acceptance (latency 1).
- Outputs in ISSUE:
  - line_x_out = base_x + ox, modulo 2^(X_WDTH-C_L_H_SIZE_C); wrap-around is intentional, no saturation.
  - line_y_out = base_y + oy, same modulo rule on Y.
  - line_last_out = (ox==dx) & (oy==dy).
- Advance only on line_valid_out & line_ready_in, in raster order (x inner):
  - if ox<dx: ox++
  - else: ox=0, oy++
- On a handshake while line_last_out=1: ISSUE->IDLE. req_ready_out returns to 1 on the next cycle; back-to-back requests have one idle bubble.
- Lines per request = (dx+1)*(dy+1), range 1..16. dx=dy=0 gives exactly one line with line_last_out=1.
- Backpressure: while line_valid_out=1 and line_ready_in=0, every output holds its value and the offsets do not change.
- req_valid_in while in ISSUE is ignored; the request stays pending upstream because req_ready_out=0.
- Input fields are sampled only at acceptance; later changes on start_*/delta_* have no effect.
- Reset asserted in any state, including mid-stream: next cycle is IDLE with all outputs at their reset values. The partial request is discarded and no line_last_out is emitted.
- No combinational path from line_ready_in to line_valid_out; outputs are driven from registered state.

Test Plan:
- Reset, then start_x=15, start_y=6, dx=1, dy=1, line_ready_in=1:
  - expect (1,1), (2,1), (1,2), (2,2) on 4 consecutive cycles starting 1 cycle after acceptance.
  - last=1 only on (2,2); req_ready_out=1 on the following cycle.
- start_x=0, start_y=0, dx=0, dy=0 -> single line (0,0) with last=1; busy_out high for exactly 1 cycle.
- start_x=2047, start_y=2047, dx=1, dy=1 -> (255,511), (0,511), (255,0), (0,0); checks wrap on both axes.
- dx=3, dy=3, start_x=64, start_y=32; line_ready_in toggles 1,0,1,0,... ->
  - 16 lines, (8..11, 8..11) in raster order.
  - Outputs stable on every stalled cycle; last only on (11,11).
- Mid-stream reset: dx=1, dy=2, assert reset after the 3rd handshake ->
  - next cycle line_valid_out=0, req_ready_out=1.
  - A new request of dx=0, dy=0 then produces exactly one line.
- Hold req_valid_in=1 continuously with two queued requests A(dx=1,dy=0) and B(dx=0,dy=0) ->
  - A yields 2 lines, one bubble cycle, then B yields 1 line.
  - B is never accepted during ISSUE.
